// File: rtl/ofifo_pkg.sv
// Shared sizing helpers and lane-packing macro for the output FIFO collector and the psum SRAM writer.
`define OFIFO_LANE(bus, i, bw) bus[(i)*(bw) +: (bw)]

package ofifo_pkg;

   localparam int COL     = 8;
   localparam int PSUM_BW = 16;
   localparam int DEPTH   = 64;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   // One extra pointer bit separates the full and empty cases when the address bits match.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int ADDR_W = addr_w(DEPTH);
   localparam int PTR_W  = ptr_w(DEPTH);

endpackage

// File: rtl/ofifo_lane.sv
// Single-clock show-ahead FIFO holding one array column's psums; the top drives a common pop.
module ofifo_lane
   import ofifo_pkg::*;
#(
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = DEPTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr,
   input  logic               rd,
   input  logic [psum_bw-1:0] in,
   output logic [psum_bw-1:0] out,
   output logic               o_empty,
   output logic               o_full
);

   localparam int AW = addr_w(depth);
   localparam int PW = ptr_w(depth);

   logic [psum_bw-1:0] mem_q [depth];
   logic [PW-1:0]      wp_q, wp_d;
   logic [PW-1:0]      rp_q, rp_d;
   logic               do_wr, do_rd;

   // NOTE: every signal written here is assigned on every path, so no latch is inferred.
   always_comb begin
      o_empty = (wp_q == rp_q);
      o_full  = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
      do_wr   = wr && !o_full;
      do_rd   = rd && !o_empty;
      wp_d    = do_wr ? wp_q + PW'(1) : wp_q;
      rp_d    = do_rd ? rp_q + PW'(1) : rp_q;
   end

   // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wp_q[AW-1:0]] <= in;
      end
   end

   assign out = mem_q[rp_q[AW-1:0]];

endmodule

// File: rtl/ofifo_collect.sv
// Re-aligns diagonally skewed column psums into complete rows for the psum memory writer.
module ofifo_collect
   import ofifo_pkg::*;
#(
   parameter int col     = COL,
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col*psum_bw-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   output logic [col*psum_bw-1:0] out,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_ready,
   output logic                   o_overflow
);

   logic [col-1:0]         lane_empty;
   logic [col-1:0]         lane_full;
   logic [col*psum_bw-1:0] head_row;
   logic                   pop;
   logic                   overflow_q, overflow_d;

   for (genvar i = 0; i < col; i++) begin : g_lane
      ofifo_lane #(
         .psum_bw (psum_bw),
         .depth   (depth)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .wr      (wr[i]),
         .rd      (pop),
         .in      (`OFIFO_LANE(in, i, psum_bw)),
         .out     (`OFIFO_LANE(head_row, i, psum_bw)),
         .o_empty (lane_empty[i]),
         .o_full  (lane_full[i])
      );
   end

   // A pop only happens when every lane has an entry, so rows never tear.
   always_comb begin
      o_valid    = &(~lane_empty);
      o_full     = |lane_full;
      o_ready    = ~o_full;
      pop        = rd && o_valid;
      out        = o_valid ? head_row : '0;
      overflow_d = overflow_q | (|(wr & lane_full));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign o_overflow = overflow_q;

endmodule
